// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
// ---------------------------------------------------------------------------
// Single-clock first-word-fall-through FIFO built around a registered-output
// dual-port RAM. The controller owns the write/read pointers, the count of
// words still sitting in the RAM, and the valid/ready flow control on both
// sides. The head word is prefetched into the RAM output register, so
// out_data is driven directly by that register.
//
// Parameters
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  RAM address width; capacity is 2^ADDR_WIDTH words
//
// Ports
//   clock      single clock for all logic and both RAM ports
//   reset      asynchronous, active-high reset
//   in_valid   upstream word present
//   in_ready   FIFO accepts a word this cycle (decoded from registers only)
//   in_data    upstream word
//   out_valid  out_data holds the head word
//   out_ready  downstream takes the head word this cycle
//   out_data   head word, straight from the RAM output register
//   level      words held (RAM plus head)
//
// Build option
//   FIFO_SYNC_CTRL_LEVEL_EN  when defined, level is a registered copy of the
//                            occupancy; when undefined, level is tied to 0.
//                            Flow control is identical in both builds.
// ---------------------------------------------------------------------------
module fifo_sync_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned       DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

  // Controller state
  logic [ADDR_WIDTH-1:0] wptr_reg;
  logic [ADDR_WIDTH-1:0] rptr_reg;
  logic [ADDR_WIDTH:0]   ram_count_reg;
  logic [ADDR_WIDTH:0]   ram_count_next;
  logic                  out_valid_reg;
  logic                  out_valid_next;
  logic [ADDR_WIDTH:0]   occupancy;

  // Handshake decode
  logic push;
  logic pop;
  logic fetch;

  // RAM storage and its registered read port (neither is reset)
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  assign occupancy = ram_count_reg + {{ADDR_WIDTH{1'b0}}, out_valid_reg};

  // Ready depends on registers only, so a pop from full does not open the
  // input in the same cycle; there is no combinational ready path.
  assign in_ready = (occupancy < DEPTH_L);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_reg & out_ready;

  // The fetch test uses the pre-write count, so the word being written this
  // cycle can never be the one read: no read/write collision handling needed.
  assign fetch = (ram_count_reg != '0) & (~out_valid_reg | out_ready);

  always_comb begin
    ram_count_next = ram_count_reg;
    case ({push, fetch})
      2'b10:   ram_count_next = ram_count_reg + ONE_L;
      2'b01:   ram_count_next = ram_count_reg - ONE_L;
      default: ram_count_next = ram_count_reg;
    endcase
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    if (fetch) begin
      out_valid_next = 1'b1;
    end else if (pop) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      ram_count_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (fetch) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      ram_count_reg <= ram_count_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // RAM write port. Writes during reset are harmless: the pointers return to
  // zero, so anything stored is unreachable.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr_reg] <= in_data;
    end
  end

  // RAM read port: the output register doubles as the FIFO head register.
  always_ff @(posedge clock) begin
    if (fetch) begin
      rdata_reg <= mem[rptr_reg];
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = rdata_reg;

`ifdef FIFO_SYNC_CTRL_LEVEL_EN
  logic [ADDR_WIDTH:0] level_reg;

  // Tracks the occupancy the other state registers will hold after this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_reg <= '0;
    end else begin
      level_reg <= ram_count_next + {{ADDR_WIDTH{1'b0}}, out_valid_next};
    end
  end

  assign level = level_reg;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;

  fifo_sync_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level)
  );

  always #5 clock = ~clock;

  // Reference model: an ordered list of stored words, each tagged with the
  // clock edge on which it was accepted. A word is visible at the output once
  // it is the oldest word held and at least one edge has passed since it
  // was accepted.
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] dut_popped[$];
  int            cyc;
  int            checks;
  int            fails;
  int            pop_count;
  int            max_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].c < cyc);
  endfunction

  task automatic check_all();
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid()});
    if (exp_valid()) begin
      chk("out_data", {24'd0, out_data}, {24'd0, q[0].d});
    end
`ifdef FIFO_SYNC_CTRL_LEVEL_EN
    chk("level", {29'd0, level}, q.size());
`else
    chk("level", {29'd0, level}, 32'd0);
`endif
  endtask

  // One clock cycle: drive inputs, predict the handshakes, advance the model
  // on the edge, then compare all outputs 1 time unit later.
  task automatic step(input bit iv, input logic [DW-1:0] id, input bit ordy);
    bit push;
    bit pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    push = iv && (q.size() < DEPTH);
    pop  = exp_valid() && ordy;
    if (pop) dut_popped.push_back(out_data);
    @(posedge clock);
    cyc++;
    if (pop) begin
      void'(q.pop_front());
      pop_count++;
    end
    if (push) q.push_back('{id, cyc});
    if (q.size() > max_occ) max_occ = q.size();
    #1;
    check_all();
  endtask

  initial begin
    bit            iv;
    bit            ordy;
    logic [DW-1:0] held;
    bit            holding;

    checks = 0; fails = 0; cyc = 0; pop_count = 0; max_occ = 0;
    in_valid = 0; in_data = '0; out_ready = 0;

    // Reset state
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;
    chk("rst_level", {29'd0, level}, 32'd0);
    reset = 1'b0;
    #1;
    check_all();

    // Single word: visible after edge 1, gone after edge 2
    step(1'b1, 8'h11, 1'b1);
    chk("single_valid_e0", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("single_valid_e1", {31'd0, out_valid}, 32'd1);
    chk("single_data_e1", {24'd0, out_data}, 32'h11);
    step(1'b0, 8'h00, 1'b1);
    chk("single_valid_e2", {31'd0, out_valid}, 32'd0);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef FIFO_SYNC_CTRL_LEVEL_EN
    chk("fill_level", {29'd0, level}, 32'd4);
`else
    chk("fill_level", {29'd0, level}, 32'd0);
`endif
    step(1'b1, 8'h05, 1'b0);
    chk("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    dut_popped.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_count", dut_popped.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_popped.size()) chk("drain_data", {24'd0, dut_popped[i]}, i + 1);
    end

    // Streaming: 16 words back to back with out_ready held high
    pop_count = 0; max_occ = 0; dut_popped.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("stream_count", pop_count, 32'd16);
    chk("stream_max_occ", {31'd0, max_occ <= 2}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i < dut_popped.size()) chk("stream_data", {24'd0, dut_popped[i]}, i);
    end

    // Reset mid-stream with 3 words held
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("midrst_level", {29'd0, level}, 32'd0);
    check_all();
    step(1'b1, 8'h5A, 1'b0);
    chk("post_rst_e0", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", {24'd0, out_data}, 32'h5A);
    step(1'b0, 8'h00, 1'b1);

    // Random back-pressure against the reference queue
    holding = 1'b0;
    held    = '0;
    for (int i = 0; i < 1000; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 2) != 0) & (i % 97 > 20);
      if (holding && out_valid) chk("hold_stable", {24'd0, out_data}, {24'd0, held});
      holding = out_valid && !ordy;
      held    = out_data;
      step(iv, 8'($urandom), ordy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
